rtc_bus_ctrl: RTL and testbench
===============================

RTC_BUS_CTRL -- requirements
Module: rtc_bus_ctrl

Interface
REQ-001 Parameter T_PH, default 4, sets cycles per bus phase; legal range 1..255.
REQ-002 clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  one-cycle transaction request, driven from the RTC port-decode enable qualified by a port strobe.
REQ-005 rw  in  1  transaction type, sampled with start: 1 = read, 0 = write.
REQ-006 addr  in  8  RTC register address, sampled with start.
REQ-007 wdata  in  8  write data, sampled with start.
REQ-008 ad_in  in  8  RTC multiplexed address/data bus, read path.
REQ-009 busy  out  1  high while a transaction is in progress.
REQ-010 done  out  1  one-cycle pulse at transaction end.
REQ-011 rdata  out  8  last read result; holds its value between reads.
REQ-012 cs_n  out  1  RTC chip select, active low.
REQ-013 rd_n  out  1  RTC read strobe, active low.
REQ-014 wr_n  out  1  RTC write strobe, active low.
REQ-015 ad_sel  out  1  RTC A/D pin: 1 = address phase, 0 = data phase.
REQ-016 ad_out  out  8  multiplexed bus, write path.
REQ-017 ad_oe  out  1  tristate enable for ad_out; 1 = drive.

Function
REQ-018 States SHALL be IDLE, A_SET, A_STB, A_HLD, GAP, D_SET, D_STB, D_HLD and DONE; each phase state lasts exactly T_PH cycles, counted by an 8-bit phase counter.
REQ-019 In IDLE, start=1 SHALL latch rw, addr and wdata and move to A_SET on the next edge; busy SHALL rise in that same edge.
REQ-020 While busy=1 or in DONE, start SHALL be ignored and the latched fields SHALL NOT change.
REQ-021 In A_SET, A_STB and A_HLD: cs_n=0, ad_sel=1, ad_oe=1 and ad_out=addr; wr_n=0 only in A_STB.
REQ-022 In GAP: cs_n=1, ad_oe=0, and rd_n=wr_n=1.
REQ-023 In D_SET, D_STB and D_HLD: cs_n=0 and ad_sel=0.
- Write: ad_oe=1, ad_out=wdata, and wr_n=0 only in D_STB.
- Read: ad_oe=0, and rd_n=0 only in D_STB.
REQ-024 On a read, rdata SHALL load ad_in on the clock edge that ends the last D_STB cycle.
REQ-025 DONE SHALL last 1 cycle with done=1, cs_n=1 and ad_oe=0; the next edge SHALL return to IDLE with busy=0.
REQ-026 Latency: with start sampled at edge 0, done SHALL be high during the cycle after edge 7*T_PH, which is the 29th cycle for T_PH=4.
REQ-027 rd_n and wr_n SHALL never be low together, and neither SHALL be low while cs_n=1.
REQ-028 All bus outputs SHALL be registered, so there are no combinational glitches on the strobes.
REQ-029 A start arriving during DONE SHALL be lost; the requester re-issues it once busy=0.

Reset
REQ-030 When reset=1, the following SHALL apply immediately and independently of clk:
- state = IDLE and the phase counter = 0;
- busy = 0 and done = 0;
- cs_n = rd_n = wr_n = 1;
- ad_sel = 1 and ad_oe = 0;
- ad_out = 0 and rdata = 0.
REQ-031 Reset asserted mid-transaction SHALL abort it with no done pulse; the first start after reset is released SHALL be accepted normally.

Verification
REQ-032 Write, T_PH=4: start with rw=0, addr=0x21, wdata=0x59 -> the bench SHALL see:
- ad_out=0x21 with ad_sel=1 and a 4-cycle wr_n low pulse;
- cs_n high for 4 cycles;
- ad_out=0x59 with ad_sel=0 and a 4-cycle wr_n low pulse;
- done in the 29th cycle.
REQ-033 Read, T_PH=4: start with rw=1, addr=0x22, ad_in=0x47 during D_STB -> ad_oe=0 in the data phase, a 4-cycle rd_n pulse, rdata=0x47 when done=1, and rdata still 0x47 afterwards.
REQ-034 Collision: start with addr=0x30 pulsed while in A_STB of a write to 0x21 -> no effect; the data phase still drives the original wdata, and exactly one done is produced.
REQ-035 Reset during D_STB of a write -> wr_n=1 and cs_n=1 within the same cycle, with no done; a subsequent read then completes normally.
REQ-036 T_PH=1: write immediately followed by a read (start re-issued on the first cycle with busy=0) -> each phase lasts 1 cycle, done comes 8 cycles after each accepted start, and the strobe-exclusion rule REQ-027 is checked every cycle.

Source files
------------

// File: rtl/rtc_bus_ctrl.sv
// rtc_bus_ctrl: sequences one RTC bus transaction (address phase, gap,
// data phase) on a multiplexed address/data bus. Every phase lasts T_PH
// cycles. All bus outputs come straight from flops so the strobes cannot
// glitch.
module rtc_bus_ctrl #(
  parameter int T_PH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic [7:0] ad_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_sel,
  output logic [7:0] ad_out,
  output logic       ad_oe
);

  typedef enum logic [3:0] {
    IDLE, A_SET, A_STB, A_HLD, GAP, D_SET, D_STB, D_HLD, DONE
  } state_t;

  // Output bundle, registered as a whole so that all outputs track the state.
  typedef struct packed {
    logic       busy;
    logic       done;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       ad_sel;
    logic       ad_oe;
    logic [7:0] ad_out;
  } bus_t;

  localparam logic [7:0] PH_LAST = 8'(T_PH - 1);

  state_t     state_r;
  logic [7:0] cnt_r;
  logic       rw_r;
  logic [7:0] addr_r;
  logic [7:0] wdata_r;
  logic [7:0] rdata_r;
  bus_t       bus_r;

  // Output values to present while sitting in a given state.
  function automatic bus_t bus_for(input state_t st, input logic t_rw,
                                   input logic [7:0] t_addr,
                                   input logic [7:0] t_wdata);
    bus_t b;
    b.busy   = 1'b1;
    b.done   = 1'b0;
    b.cs_n   = 1'b1;
    b.rd_n   = 1'b1;
    b.wr_n   = 1'b1;
    b.ad_sel = 1'b1;
    b.ad_oe  = 1'b0;
    b.ad_out = 8'h00;
    case (st)
      IDLE: b.busy = 1'b0;
      A_SET, A_STB, A_HLD: begin
        b.cs_n   = 1'b0;
        b.ad_oe  = 1'b1;
        b.ad_out = t_addr;
        b.wr_n   = (st == A_STB) ? 1'b0 : 1'b1;
      end
      GAP: b.ad_sel = 1'b0;
      D_SET, D_STB, D_HLD: begin
        b.cs_n   = 1'b0;
        b.ad_sel = 1'b0;
        b.ad_oe  = ~t_rw;
        b.ad_out = t_rw ? 8'h00 : t_wdata;
        if (st == D_STB) begin
          if (t_rw) begin
            b.rd_n = 1'b0;
          end else begin
            b.wr_n = 1'b0;
          end
        end
      end
      DONE: b.done = 1'b1;
      default: b.busy = 1'b0;
    endcase
    return b;
  endfunction

  // Successor of each timed phase; anything unexpected falls back to IDLE.
  function automatic state_t next_phase(input state_t st);
    state_t n;
    case (st)
      A_SET:   n = A_STB;
      A_STB:   n = A_HLD;
      A_HLD:   n = GAP;
      GAP:     n = D_SET;
      D_SET:   n = D_STB;
      D_STB:   n = D_HLD;
      D_HLD:   n = DONE;
      default: n = IDLE;
    endcase
    return n;
  endfunction

  // Transaction FSM: latches the request, times each phase and registers outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
      rw_r    <= 1'b0;
      addr_r  <= 8'h00;
      wdata_r <= 8'h00;
      rdata_r <= 8'h00;
      bus_r   <= bus_for(IDLE, 1'b0, 8'h00, 8'h00);
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            rw_r    <= rw;
            addr_r  <= addr;
            wdata_r <= wdata;
            cnt_r   <= 8'd0;
            state_r <= A_SET;
            bus_r   <= bus_for(A_SET, rw, addr, wdata);
          end
        end
        DONE: begin
          state_r <= IDLE;
          bus_r   <= bus_for(IDLE, rw_r, addr_r, wdata_r);
        end
        default: begin
          if (cnt_r == PH_LAST) begin
            cnt_r   <= 8'd0;
            state_r <= next_phase(state_r);
            bus_r   <= bus_for(next_phase(state_r), rw_r, addr_r, wdata_r);
            // Read data is captured as the strobe phase closes.
            if (state_r == D_STB && rw_r) begin
              rdata_r <= ad_in;
            end
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
      endcase
    end
  end

  assign busy   = bus_r.busy;
  assign done   = bus_r.done;
  assign cs_n   = bus_r.cs_n;
  assign rd_n   = bus_r.rd_n;
  assign wr_n   = bus_r.wr_n;
  assign ad_sel = bus_r.ad_sel;
  assign ad_oe  = bus_r.ad_oe;
  assign ad_out = bus_r.ad_out;
  assign rdata  = rdata_r;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Bench for rtc_bus_ctrl: one instance with T_PH=4 and one with T_PH=1.
// Expected transactions are queued when issued and retired when done pulses.
module tb_rtc_bus_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, rw, sel;
  logic [7:0] addr, wdata, ad_in;

  logic       start_a, busy_a, done_a, cs_n_a, rd_n_a, wr_n_a, ad_sel_a, ad_oe_a;
  logic [7:0] rdata_a, ad_out_a;
  logic       start_b, busy_b, done_b, cs_n_b, rd_n_b, wr_n_b, ad_sel_b, ad_oe_b;
  logic [7:0] rdata_b, ad_out_b;

  logic       o_busy, o_done, o_cs_n, o_rd_n, o_wr_n, o_ad_sel, o_ad_oe;
  logic [7:0] o_rdata, o_ad_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  rtc_bus_ctrl #(.T_PH(4)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .rw(rw), .addr(addr),
    .wdata(wdata), .ad_in(ad_in), .busy(busy_a), .done(done_a),
    .rdata(rdata_a), .cs_n(cs_n_a), .rd_n(rd_n_a), .wr_n(wr_n_a),
    .ad_sel(ad_sel_a), .ad_out(ad_out_a), .ad_oe(ad_oe_a)
  );

  rtc_bus_ctrl #(.T_PH(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .rw(rw), .addr(addr),
    .wdata(wdata), .ad_in(ad_in), .busy(busy_b), .done(done_b),
    .rdata(rdata_b), .cs_n(cs_n_b), .rd_n(rd_n_b), .wr_n(wr_n_b),
    .ad_sel(ad_sel_b), .ad_out(ad_out_b), .ad_oe(ad_oe_b)
  );

  assign o_busy   = sel ? busy_b   : busy_a;
  assign o_done   = sel ? done_b   : done_a;
  assign o_cs_n   = sel ? cs_n_b   : cs_n_a;
  assign o_rd_n   = sel ? rd_n_b   : rd_n_a;
  assign o_wr_n   = sel ? wr_n_b   : wr_n_a;
  assign o_ad_sel = sel ? ad_sel_b : ad_sel_a;
  assign o_ad_oe  = sel ? ad_oe_b  : ad_oe_a;
  assign o_rdata  = sel ? rdata_b  : rdata_a;
  assign o_ad_out = sel ? ad_out_b : ad_out_a;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Issue one transaction and check every cycle against the phase model.
  task automatic do_txn(input int tph, input logic t_rw, input logic [7:0] t_addr,
                        input logic [7:0] t_wdata, input logic [7:0] t_rd,
                        input logic collide);
    exp_t e, r;
    int   p;
    logic ecs, eoe, ewr, erd;
    e.rw = t_rw; e.addr = t_addr; e.wdata = t_wdata; e.rd = t_rd;
    sb.push_back(e);
    rw = t_rw; addr = t_addr; wdata = t_wdata; ad_in = 8'hEE; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 7 * tph + 1; k++) begin
      p = (k - 1) / tph;
      if (collide && k == tph + 1) begin
        start = 1'b1; addr = 8'h30; wdata = 8'hA5; rw = ~t_rw;
      end else begin
        start = 1'b0;
      end
      ad_in = (t_rw && p == 5) ? t_rd : 8'hEE;
      e   = sb[0];
      ecs = (p == 3 || p == 7);
      eoe = (p <= 2) || (p >= 4 && p <= 6 && !e.rw);
      ewr = !((p == 1) || (p == 5 && !e.rw));
      erd = !(p == 5 && e.rw);
      check($sformatf("busy@%0d", k), o_busy, 1'b1);
      check($sformatf("done@%0d", k), o_done, (p == 7));
      check($sformatf("cs_n@%0d", k), o_cs_n, ecs);
      check($sformatf("ad_oe@%0d", k), o_ad_oe, eoe);
      check($sformatf("wr_n@%0d", k), o_wr_n, ewr);
      check($sformatf("rd_n@%0d", k), o_rd_n, erd);
      if (p <= 2) begin
        check($sformatf("ad_sel@%0d", k), o_ad_sel, 1'b1);
        check($sformatf("ad_out_addr@%0d", k), o_ad_out, e.addr);
      end
      if (p >= 4 && p <= 6) begin
        check($sformatf("ad_sel@%0d", k), o_ad_sel, 1'b0);
        if (!e.rw) check($sformatf("ad_out_data@%0d", k), o_ad_out, e.wdata);
      end
      check($sformatf("strobe_excl@%0d", k),
            !((!o_rd_n && !o_wr_n) || (o_cs_n && (!o_rd_n || !o_wr_n))), 1'b1);
      if (p == 7 && o_done) begin
        r = sb.pop_front();
        if (r.rw) check("rdata_at_done", o_rdata, r.rd);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("busy_after", o_busy, 1'b0);
    check("done_after", o_done, 1'b0);
    if (t_rw) check("rdata_held", o_rdata, t_rd);
  endtask

  initial begin
    sel = 1'b0; reset = 1'b1; start = 1'b0; rw = 1'b0;
    addr = 8'h00; wdata = 8'h00; ad_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", o_busy, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_cs_n", o_cs_n, 1'b1);
    check("rst_rd_n", o_rd_n, 1'b1);
    check("rst_wr_n", o_wr_n, 1'b1);
    check("rst_ad_sel", o_ad_sel, 1'b1);
    check("rst_ad_oe", o_ad_oe, 1'b0);
    check("rst_ad_out", o_ad_out, 8'h00);
    check("rst_rdata", o_rdata, 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;

    // Plain write, read, then write with a colliding start during A_STB.
    do_txn(4, 1'b0, 8'h21, 8'h59, 8'h00, 1'b0);
    do_txn(4, 1'b1, 8'h22, 8'h11, 8'h47, 1'b0);
    do_txn(4, 1'b0, 8'h21, 8'h59, 8'h00, 1'b1);

    // Reset in the first D_STB cycle of a write aborts it.
    rw = 1'b0; addr = 8'h21; wdata = 8'h59; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_wr_n_pre", o_wr_n, 1'b0);
    check("abort_cs_n_pre", o_cs_n, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("abort_wr_n", o_wr_n, 1'b1);
    check("abort_cs_n", o_cs_n, 1'b1);
    check("abort_busy", o_busy, 1'b0);
    check("abort_done", o_done, 1'b0);
    check("abort_rdata", o_rdata, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("abort_no_done", o_done, 1'b0);
      check("abort_idle", o_busy, 1'b0);
      @(posedge clk); #1;
    end
    do_txn(4, 1'b1, 8'h23, 8'h00, 8'h3C, 1'b0);

    // T_PH=1: back-to-back write then read.
    sel = 1'b1;
    #1;
    check("b_idle_busy", o_busy, 1'b0);
    do_txn(1, 1'b0, 8'h21, 8'h59, 8'h00, 1'b0);
    do_txn(1, 1'b1, 8'h22, 8'h00, 8'h47, 1'b0);

    check("sb_empty", sb.size(), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
